// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer.
//
// Holds the instruction word width, the opcode constants, the sequencer state
// encoding and small helpers that decode an instruction word.
package program_sequencer_pkg;

    // Instruction / immediate word width and opcode field layout.
    localparam int unsigned WORD_W = 9;
    localparam int unsigned OP_W   = 3;

    // Opcodes, taken from word[8:6].
    localparam logic [OP_W-1:0] OP_MV   = 3'b001;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFetchImm,
        StIssue,
        StIssueImm,
        StWaitDone,
        StHalt
    } state_e;

    // Opcode field of an instruction word.
    function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1:WORD_W-OP_W];
    endfunction

    // True for opcodes that are handed to the processor; everything except
    // these and halt is a no-op that the sequencer skips.
    function automatic logic is_issued(input logic [OP_W-1:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/program_sequencer.sv
// Program sequencer: walks a program held in a synchronous ROM and feeds each
// instruction (plus the immediate word for mvi) to a processor control unit,
// waiting for the processor's done strobe between instructions.
//
// Ports
//   clock        single clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse, (re)starts execution at address 0 from IDLE/HALT
//   rom_addr     ROM read address (current pc)
//   rom_data     ROM word, valid one cycle after rom_addr
//   run          one-cycle instruction-issue strobe
//   din          instruction / immediate word to the processor DIN bus
//   done         processor completion strobe, honoured only while waiting for it
//   busy         high in every state except IDLE and HALT
//   halted       high in HALT
//   error        sticky timeout flag, cleared by reset or start
//   instr_count  instructions completed since the last start, saturating
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              run,
    output logic [WORD_W-1:0] din,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int unsigned     CntW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    // Second cycle of a ROM read: rom_data now holds the word at pc.
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [WORD_W-1:0]   imm_q, imm_d;
    // Last word put on din; din keeps it while waiting for done.
    logic [WORD_W-1:0]   last_q, last_d;
    logic [CntW-1:0]     wait_q, wait_d;
    logic                error_q, error_d;
    logic [15:0]         count_q, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        last_d  = last_q;
        wait_d  = wait_q;
        error_d = error_q;
        count_d = count_q;
        run     = 1'b0;
        din     = last_q;

        unique case (state_q)
            StIdle, StHalt: begin
                din = '0;
                if (start) begin
                    state_d = StFetch;
                    phase_d = 1'b0;
                    pc_d    = '0;
                    last_d  = '0;
                    error_d = 1'b0;
                    count_d = '0;
                end
            end

            StFetch: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    ir_d    = rom_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    if (opcode_of(rom_data) == OP_HALT) begin
                        state_d = StHalt;
                    end else if (opcode_of(rom_data) == OP_MVI) begin
                        state_d = StFetchImm;
                    end else if (is_issued(opcode_of(rom_data))) begin
                        state_d = StIssue;
                    end else begin
                        // Undefined opcode: skip straight to the next word.
                        state_d = StFetch;
                    end
                end
            end

            StFetchImm: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    imm_d   = rom_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StIssue;
                end
            end

            StIssue: begin
                run    = 1'b1;
                din    = ir_q;
                last_d = ir_q;
                wait_d = '0;
                if (opcode_of(ir_q) == OP_MVI) begin
                    state_d = StIssueImm;
                end else begin
                    state_d = StWaitDone;
                end
            end

            StIssueImm: begin
                din     = imm_q;
                last_d  = imm_q;
                wait_d  = '0;
                state_d = StWaitDone;
            end

            StWaitDone: begin
                if (done) begin
                    state_d = StFetch;
                    phase_d = 1'b0;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end else if (wait_q == TimeoutLast) begin
                    error_d = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rom_addr    = pc_q;
    assign busy        = (state_q != StIdle) && (state_q != StHalt);
    assign halted      = (state_q == StHalt);
    assign error       = error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomised scoreboard bench for program_sequencer. A reference model executes
// each program at the instruction level and queues the expected issue words; a
// monitor pops and compares whenever the DUT pulses run. A second instance with
// a 2-bit address exercises pc wrap-around.
module tb_program_sequencer;

    localparam int MODE_HALT    = 0;
    localparam int MODE_DRAIN   = 1;
    localparam int MODE_TIMEOUT = 2;
    localparam int MODE_RESET   = 3;

    typedef struct packed {
        logic [8:0] word;
        logic       has_imm;
        logic [8:0] imm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        done = 1'b0;
    logic [6:0]  rom_addr_a;
    logic [1:0]  rom_addr_b;
    logic [8:0]  rom_data_a = '0;
    logic [8:0]  rom_data_b = '0;
    logic        run_a, run_b, busy_a, busy_b, halted_a, halted_b, error_a, error_b;
    logic [8:0]  din_a, din_b;
    logic [15:0] count_a, count_b;

    logic [8:0]  rom_a[128];
    logic [8:0]  rom_b[4];
    logic [8:0]  model_rom[128];

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          sel = 1'b0;
    bit          done_en = 1'b1;
    bit          glitch_en = 1'b0;
    int          ddelay = 3;

    logic        mon_run, mon_busy, mon_halted, mon_error;
    logic [8:0]  mon_din;
    logic [6:0]  mon_rom_addr;
    logic [15:0] mon_count;

    assign mon_run      = sel ? run_b : run_a;
    assign mon_busy     = sel ? busy_b : busy_a;
    assign mon_halted   = sel ? halted_b : halted_a;
    assign mon_error    = sel ? error_b : error_a;
    assign mon_din      = sel ? din_b : din_a;
    assign mon_rom_addr = sel ? {5'd0, rom_addr_b} : rom_addr_a;
    assign mon_count    = sel ? count_b : count_a;

    always #5 clock = ~clock;

    program_sequencer #(.ADDR_W(7), .TIMEOUT(255)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .run(run_a), .din(din_a), .done(done), .busy(busy_a),
        .halted(halted_a), .error(error_a), .instr_count(count_a)
    );

    program_sequencer #(.ADDR_W(2), .TIMEOUT(255)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .run(run_b), .din(din_b), .done(done), .busy(busy_b),
        .halted(halted_b), .error(error_b), .instr_count(count_b)
    );

    // Synchronous ROMs: data for an address appears one cycle later.
    always @(posedge clock) begin
        rom_data_a <= rom_a[rom_addr_a];
        rom_data_b <= rom_b[rom_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level model: runs the program in model_rom over an n-word
    // address space, queues every issued word and returns the completed
    // count, the pc after the last fetch and the start-to-first-run latency.
    task automatic model(input int n, input int max_issues, output int cnt, output int fpc,
                         output int lat);
        int         pc = 0;
        int         skips = 0;
        logic [8:0] w;
        logic [8:0] imm;
        logic [2:0] op;
        exp_t       e;
        cnt = 0;
        lat = -1;
        for (int it = 0; it < 1000; it++) begin
            w  = model_rom[pc];
            pc = (pc + 1) % n;
            op = w[8:6];
            if (op == 3'b111) break;
            imm = '0;
            if (op == 3'b010) begin
                imm = model_rom[pc];
                pc  = (pc + 1) % n;
            end
            if (op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
                // A fetch takes two cycles, an immediate fetch two more.
                if (lat < 0) lat = 3 + 2 * skips + ((op == 3'b010) ? 2 : 0);
                e.word    = w;
                e.has_imm = (op == 3'b010);
                e.imm     = imm;
                exp_q.push_back(e);
                cnt++;
                if (cnt == max_issues) break;
            end else begin
                skips++;
            end
        end
        fpc = pc;
    endtask

    // Monitor: compares every run pulse (and the following immediate cycle)
    // against the queued expectations.
    initial begin
        bit         pend = 1'b0;
        logic [8:0] pimm = '0;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (pend) begin
                check("imm_cycle_run", 32'(mon_run), 32'd0);
                check("imm_cycle_din", 32'(mon_din), 32'(pimm));
                pend = 1'b0;
            end else if (mon_run) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_run", 32'(mon_run), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_din", 32'(mon_din), 32'(e.word));
                    if (e.has_imm) begin
                        pend = 1'b1;
                        pimm = e.imm;
                    end
                end
            end
        end
    end

    // Processor stand-in: done arrives ddelay cycles after run; with glitch_en
    // it also pulses done at random where the sequencer must ignore it.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clock);
            if (!done_en) begin
                cnt  = 0;
                done = 1'b0;
            end else if (mon_run) begin
                cnt  = ddelay;
                done = glitch_en && ($urandom_range(0, 1) == 1);
            end else if (cnt > 0) begin
                cnt--;
                done = (cnt == 0);
            end else begin
                done = glitch_en && ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic run_prog(input bit on_b, input int max_issues, input int mode,
                            input string tag);
        int cnt, fpc, lat, k;
        for (int i = 0; i < 128; i++) rom_a[i] = model_rom[i];
        for (int i = 0; i < 4; i++) rom_b[i] = model_rom[i];
        model(on_b ? 4 : 128, max_issues, cnt, fpc, lat);
        sel = on_b;
        @(negedge clock);
        if (on_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        k = 1;
        if (lat >= 0) begin
            while (!mon_run && k < 300) begin
                @(negedge clock);
                k++;
            end
            check({tag, "_latency"}, 32'(k), 32'(lat));
        end
        k = 0;
        case (mode)
            MODE_HALT: begin
                while (!mon_halted && k < 5000) begin
                    @(negedge clock);
                    k++;
                end
                check({tag, "_halted"}, 32'(mon_halted), 32'd1);
                check({tag, "_busy"}, 32'(mon_busy), 32'd0);
                check({tag, "_error"}, 32'(mon_error), 32'd0);
                check({tag, "_count"}, 32'(mon_count), 32'(cnt));
                check({tag, "_pc"}, 32'(mon_rom_addr), 32'(fpc));
                check({tag, "_din"}, 32'(mon_din), 32'd0);
                check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
            end
            MODE_DRAIN: begin
                while (exp_q.size() != 0 && k < 5000) begin
                    @(negedge clock);
                    k++;
                end
                check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
                check({tag, "_error"}, 32'(mon_error), 32'd0);
                check({tag, "_busy"}, 32'(mon_busy), 32'd1);
            end
            MODE_TIMEOUT: begin
                while (!mon_halted && k < 400) begin
                    @(negedge clock);
                    k++;
                end
                check({tag, "_cycles"}, 32'(k), 32'd256);
                check({tag, "_error"}, 32'(mon_error), 32'd1);
                check({tag, "_halted"}, 32'(mon_halted), 32'd1);
                check({tag, "_count"}, 32'(mon_count), 32'd0);
                check({tag, "_pc"}, 32'(mon_rom_addr), 32'(fpc));
                repeat (3) @(negedge clock);
                check({tag, "_sticky"}, 32'(mon_error), 32'd1);
            end
            default: begin
                // Reset while the last queued instruction waits for done.
                while (exp_q.size() != 0 && k < 5000) begin
                    @(negedge clock);
                    k++;
                end
                repeat (2) @(negedge clock);
                check({tag, "_count_before"}, 32'(mon_count), 32'(cnt - 1));
                reset = 1'b1;
                #1;
                check({tag, "_busy"}, 32'(mon_busy), 32'd0);
                check({tag, "_run"}, 32'(mon_run), 32'd0);
                check({tag, "_din"}, 32'(mon_din), 32'd0);
                check({tag, "_count"}, 32'(mon_count), 32'd0);
                check({tag, "_pc"}, 32'(mon_rom_addr), 32'd0);
                check({tag, "_halted"}, 32'(mon_halted), 32'd0);
                repeat (2) @(negedge clock);
                reset = 1'b0;
            end
        endcase
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) model_rom[i] = 9'o700;
    endtask

    initial begin
        int len;
        for (int i = 0; i < 128; i++) rom_a[i] = 9'o700;
        for (int i = 0; i < 4; i++) rom_b[i] = 9'o700;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_run", 32'(run_a), 32'd0);
        check("reset_din", 32'(din_a), 32'd0);
        check("reset_halted", 32'(halted_a), 32'd0);
        check("reset_error", 32'(error_a), 32'd0);
        check("reset_count", 32'(count_a), 32'd0);
        check("reset_rom_addr", 32'(rom_addr_a), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        clear_rom();
        model_rom[0] = 9'o101;
        run_prog(1'b0, 1000, MODE_HALT, "mv_halt");

        clear_rom();
        model_rom[0] = 9'o220;
        model_rom[1] = 9'h05A;
        run_prog(1'b0, 1000, MODE_HALT, "mvi_halt");

        clear_rom();
        model_rom[0] = 9'o012;
        model_rom[1] = 9'o312;
        run_prog(1'b0, 1000, MODE_HALT, "skip_noop");

        clear_rom();
        model_rom[0] = 9'o301;
        done_en = 1'b0;
        run_prog(1'b0, 1, MODE_TIMEOUT, "timeout");
        done_en = 1'b1;

        clear_rom();
        model_rom[0] = 9'o101;
        run_prog(1'b0, 1000, MODE_HALT, "restart");

        clear_rom();
        model_rom[0] = 9'o101;
        model_rom[1] = 9'o301;
        ddelay = 6;
        run_prog(1'b0, 2, MODE_RESET, "reset_wait");
        ddelay = 3;
        clear_rom();
        model_rom[0] = 9'o412;
        run_prog(1'b0, 1000, MODE_HALT, "after_reset");

        glitch_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            clear_rom();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) model_rom[i] = 9'($urandom_range(0, 511));
            ddelay = $urandom_range(2, 6);
            run_prog(1'b0, 1000, MODE_HALT, "random");
        end
        glitch_en = 1'b0;
        ddelay = 3;

        clear_rom();
        model_rom[0] = 9'o301;
        model_rom[1] = 9'o312;
        model_rom[2] = 9'o323;
        model_rom[3] = 9'o245;
        run_prog(1'b1, 5, MODE_DRAIN, "wrap");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sel = 1'b0;
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7: program ROM address width (128 words).
REQ-002 Parameter TIMEOUT, default 255: max cycles waited for done per instruction.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins execution from address 0 when idle or halted.
REQ-006 rom_addr  output  ADDR_W  program ROM read address.
REQ-007 rom_data  input  9  ROM word, valid one cycle after rom_addr (synchronous ROM).
REQ-008 run  output  1  instruction-issue strobe to the processor control unit.
REQ-009 din  output  9  instruction/immediate word to the processor DIN bus.
REQ-010 done  input  1  processor completion strobe for the current instruction.
REQ-011 busy  output  1  high in every state except IDLE and HALT.
REQ-012 halted  output  1  high in HALT.
REQ-013 error  output  1  sticky timeout flag, cleared only by reset or start.
REQ-014 instr_count  output  16  instructions completed since last start, saturating at 16'hFFFF.

Function
REQ-015 Instruction word: opcode din[8:6], Rx din[5:3], Ry din[2:0]; opcodes 001 mv, 010 mvi, 011 add, 100 sub, 111 halt; all others are treated as no-op and skipped without issue.
REQ-016 States: IDLE, FETCH, FETCH_IMM, ISSUE, ISSUE_IMM, WAIT_DONE, HALT.
REQ-017 IDLE/HALT -> FETCH on start; pc, instr_count, error cleared to 0 on the same edge.
REQ-018 FETCH: rom_addr = pc, waits one cycle for rom_data, latches it into the instruction register, pc increments.
REQ-019 After FETCH: opcode 111 -> HALT; 010 -> FETCH_IMM; undefined -> FETCH (next word); else -> ISSUE.
REQ-020 FETCH_IMM: rom_addr = pc, latches the following word as the immediate one cycle later, pc increments, -> ISSUE.
REQ-021 ISSUE: run = 1 for exactly one cycle with din = instruction register; mvi -> ISSUE_IMM, otherwise -> WAIT_DONE.
REQ-022 ISSUE_IMM: run = 0, din = immediate for exactly one cycle, -> WAIT_DONE.
REQ-023 WAIT_DONE: din holds last driven word, run = 0; done = 1 -> FETCH with instr_count incremented (saturating).
REQ-024 Issue latency: run asserts 2 cycles after entering FETCH (non-mvi), 4 cycles (mvi).
REQ-025 done sampled in WAIT_DONE only; done in any other state is ignored.
REQ-026 done arriving on the ISSUE_IMM edge is ignored; the processor shall not finish mvi before its immediate cycle.
REQ-027 Timeout: WAIT_DONE cycle counter reaching TIMEOUT without done sets error and -> HALT.
REQ-028 pc wraps from 2^ADDR_W-1 to 0 with no flag; an immediate fetched at the last address takes its word from address 0.
REQ-029 start while busy is ignored.
REQ-030 din = 0 and run = 0 in IDLE and HALT.

Reset
REQ-031 Reset asynchronously forces IDLE, pc = 0, rom_addr = 0, run = 0, din = 0, busy = 0, halted = 0, error = 0, instr_count = 0, instruction and immediate registers = 0.
REQ-032 Reset mid-instruction abandons the instruction with no further run pulse; operation resumes only on a later start.

Structure
REQ-033 Shared package holds opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_HALT), the 9-bit word width, and the state encoding.
REQ-034 Single module, no sub-modules; the timeout counter and pc are in-line registers.

Verification
REQ-035 ROM {mv R0,R1; halt}, done 3 cycles after run -> one run pulse with din=9'o101, instr_count=1, halted=1, error=0.
REQ-036 ROM {mvi R2 with imm 9'h05A; halt} -> run with din=9'o220, next cycle din=9'h05A run=0, pc=3 at halt.
REQ-037 done never asserted, TIMEOUT=255 -> error=1 and halted=1 exactly 255 cycles after entering WAIT_DONE.
REQ-038 Opcode 000 at address 0, add at address 1 -> no run for word 0, first run carries the add word.
REQ-039 Reset asserted during WAIT_DONE -> all outputs at reset values immediately; start pulse then re-fetches from address 0.
REQ-040 ADDR_W=2, ROM {add,add,add,mvi} with immediate at address 0 -> pc wraps, immediate = ROM[0], no error.
